rr_xor_scan_array: RTL
======================

Name: rr_xor_scan_array

Overview:
- NCH-channel, WD-bit XOR-scan engine behind one shared round-robin arbiter.
- Each cycle at most one channel with a pending input is granted. Its word is transformed by a selectable scan:
  - mode 0: prefix XOR (gray-to-binary style)
  - mode 1: adjacent XOR (binary-to-gray style)
- The result is registered into that channel's output slot under a valid/ready handshake.
- Successor to the fixed 5-channel counter-selected XOR-chain array: parametrised channel count and width, backpressure, a mode select and a grant counter.

Parameters:
- NCH, 5, number of channels (>=1)
- WD, 4, data width per channel (>=1)
- CW, 16, width of the grant statistics counter

Ports:
- CLK, input, 1, single clock, rising edge
- RST, input, 1, synchronous active-high reset
- in_data, input, NCH*WD, channel c occupies bits [c*WD +: WD]
- in_valid, input, NCH, per-channel input valid
- in_ready, output, NCH, per-channel grant (combinational, one-hot or zero)
- mode, input, 1, scan select applied to the granted word in the grant cycle
- out_data, output, NCH*WD, per-channel registered result
- out_valid, output, NCH, per-channel result valid
- out_ready, input, NCH, per-channel consumer ready
- grant_cnt, output, CW, total grants since reset (wraps modulo 2^CW)

Behaviour:
- Reset: on a rising CLK edge with RST=1:
  - ptr=0, out_valid=0, out_data=0, grant_cnt=0
  - in_ready is forced to 0 while RST=1.
  - Reset mid-transfer discards any granted word and all pending results.
- Slot free: slot c is free when out_valid[c]=0 OR out_ready[c]=1. A same-cycle drain and refill is allowed.
- Eligibility: channel c is eligible when in_valid[c]=1 AND slot c is free.
- Arbitration (combinational):
  - Search c = ptr, ptr+1, … modulo NCH. The first eligible channel is granted: in_ready[c]=1, all others 0.
  - No eligible channel: in_ready=0.
- Grant edge, for granted channel g:
  - out_data[g] <= scan(in_data[g], mode)
  - out_valid[g] <= 1
  - ptr <= (g+1) mod NCH
  - grant_cnt <= grant_cnt+1
- No grant: ptr and grant_cnt hold.
- Drain: out_ready[c]=1 with out_valid[c]=1 and no refill of c clears out_valid[c]. out_data[c] holds its last value.
- Hold: while out_valid[c]=1 and out_ready[c]=0, out_data[c] and out_valid[c] are stable.
- Latency: a word granted at edge k appears at out_data/out_valid after edge k. Throughput is 1 grant per cycle across all channels.
- Scan, for word d of WD bits:
  - mode 0: r[0]=d[0]; r[j]=r[j-1]^d[j] for j=1..WD-1
  - mode 1: r[0]=d[0]; r[j]=d[j]^d[j-1]
  - The two modes are mutual inverses. WD=1 gives r=d.
- Pointer: width max(1,clog2(NCH)). Wraps NCH-1 -> 0. NCH=1 keeps ptr=0.
- in_data/mode of non-granted channels are ignored. An X on a non-granted channel must not propagate.

Decomposition:
- Shared package:
  - mode encodings: MODE_PREFIX=1'b0, MODE_ADJ=1'b1
  - a clog2 function for the ptr width
- Sub-module rr_xor_scan_lane: combinational WD-bit scan (d, mode -> r), built with a generate loop.
  - The top holds one instance, shared by the granted channel through an NCH:1 input mux.
  - The top also holds the arbiter, ptr, output slot registers and grant_cnt.

Test Plan (all with NCH=5, WD=4):
- Scan values: single channel, in_data[0]=4'b1011.
  - mode 0 -> out_data[0]=4'b1001 one cycle later.
  - mode 1 -> 4'b1101.
  - Feed 4'b1001 with mode 1 -> 4'b1011 (inverse).
- Round-robin: all in_valid=1, all out_ready=1 after reset -> grants 0,1,2,3,4,0 on consecutive cycles; grant_cnt=6 after 6 cycles.
- Backpressure: out_valid[2]=1 and out_ready[2]=0, all in_valid=1 from ptr=2.
  - Channel 2 is skipped and channel 3 is granted; in_ready[2]=0; out_data[2] is stable.
  - Raising out_ready[2] the next cycle allows a same-cycle drain and refill of channel 2 when ptr reaches it.
- Sparse valid: only in_valid[4]=1 with ptr=0 -> channel 4 granted and ptr becomes 0. Then only in_valid[1]=1 -> channel 1 granted.
- Reset mid-operation: RST=1 for one edge while out_valid=5'b10110 and grant_cnt=7.
  - Next cycle: out_valid=0, out_data=0, grant_cnt=0, ptr=0.
  - in_ready=0 during the RST=1 cycle.
- Counter wrap, CW=3: 9 grants -> grant_cnt=1.

Source files
------------

// File: rtl/rr_xor_scan_array_pkg.sv
// Shared definitions for the round-robin XOR-scan array: scan mode encodings
// and the pointer-width helper.
package rr_xor_scan_array_pkg;

  localparam logic MODE_PREFIX = 1'b0;
  localparam logic MODE_ADJ    = 1'b1;

  // ceil(log2(n)), never less than 1 so a single-channel build still has a pointer bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_xor_scan_lane.sv
// Combinational WD-bit XOR scan: prefix XOR (mode 0) or adjacent XOR (mode 1).
// Zero latency, no flow control.
module rr_xor_scan_lane
  import rr_xor_scan_array_pkg::*;
#(
  parameter int WD = 4
) (
  input  logic [WD-1:0] d,
  input  logic          mode,
  output logic [WD-1:0] r
);

  logic [WD-1:0] pfx;
  logic [WD-1:0] adj;

  // Each prefix bit is a reduction over d[j:0], which avoids a bit-to-bit chain on one vector
  for (genvar j = 0; j < WD; j++) begin : g_bit
    assign pfx[j] = ^d[j:0];
    if (j == 0) begin : g_lsb
      assign adj[j] = d[j];
    end else begin : g_upper
      assign adj[j] = d[j] ^ d[j-1];
    end
  end

  assign r = (mode == MODE_PREFIX) ? pfx : adj;

endmodule

// File: rtl/rr_xor_scan_array.sv
// NCH-channel XOR-scan engine behind one round-robin arbiter; 1-cycle grant-to-output latency.
// A channel is granted only when its output slot is empty or draining in the same cycle.
module rr_xor_scan_array
  import rr_xor_scan_array_pkg::*;
#(
  parameter int NCH = 5,
  parameter int WD  = 4,
  parameter int CW  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*WD-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic              mode,
  output logic [NCH*WD-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [CW-1:0]     grant_cnt
);

  localparam int PW = clog2_min1(NCH);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gidx;
  logic              found;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    elig;
  logic [NCH*WD-1:0] data_q;
  logic [NCH-1:0]    vld_q;
  logic [CW-1:0]     cnt_q;
  logic [WD-1:0]     sel_d;
  logic [WD-1:0]     scan_r;

  assign elig = in_valid & (~vld_q | out_ready);

  // Rotating first-eligible search starting at ptr
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    grant = '0;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (!found && elig[c]) begin
        found    = 1'b1;
        gidx     = c[PW-1:0];
        grant[c] = 1'b1;
      end
    end
  end

  assign in_ready = RST ? '0 : grant;

  // Only the granted channel's word reaches the shared lane
  assign sel_d = in_data[int'(gidx)*WD +: WD];

  rr_xor_scan_lane #(.WD(WD)) u_lane (
    .d    (sel_d),
    .mode (mode),
    .r    (scan_r)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr    <= '0;
      data_q <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (found) begin
        ptr   <= (int'(gidx) == NCH-1) ? '0 : gidx + 1'b1;
        cnt_q <= cnt_q + 1'b1;
      end
      for (int c = 0; c < NCH; c++) begin
        if (grant[c]) begin
          data_q[c*WD +: WD] <= scan_r;
          vld_q[c]           <= 1'b1;
        end else if (out_ready[c]) begin
          vld_q[c] <= 1'b0;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign grant_cnt = cnt_q;

endmodule
